// File: rtl/mem_serial_pkg.sv
// Shared constants for the memory-access stage: op codes, bus widths, FSM encodings and op decode.
package mem_serial_pkg;

    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MEM_BYTE_W = 8;

    typedef logic [ALU_OP_W-1:0]   alu_op_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam alu_op_t EXE_NOP_OP = 8'h00;
    localparam alu_op_t EXE_ADD_OP = 8'h20;
    localparam alu_op_t EXE_LB_OP  = 8'hE0;
    localparam alu_op_t EXE_LH_OP  = 8'hE1;
    localparam alu_op_t EXE_LW_OP  = 8'hE2;
    localparam alu_op_t EXE_LBU_OP = 8'hE4;
    localparam alu_op_t EXE_LHU_OP = 8'hE5;
    localparam alu_op_t EXE_SB_OP  = 8'hE8;
    localparam alu_op_t EXE_SH_OP  = 8'hE9;
    localparam alu_op_t EXE_SW_OP  = 8'hEA;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_XFER = 2'd1;
    localparam logic [1:0] MEM_DONE = 2'd2;

    // last = index of the final byte (n-1): 0 for byte, 1 for half, 3 for word
    typedef struct packed {
        logic       is_mem;
        logic [1:0] last;
        logic       is_signed;
    } mem_op_t;

    function automatic mem_op_t mem_decode(input alu_op_t op);
        mem_op_t d;
        d = '0;
        case (op)
            EXE_LB_OP:             d = '{is_mem: 1'b1, last: 2'd0, is_signed: 1'b1};
            EXE_LBU_OP, EXE_SB_OP: d = '{is_mem: 1'b1, last: 2'd0, is_signed: 1'b0};
            EXE_LH_OP:             d = '{is_mem: 1'b1, last: 2'd1, is_signed: 1'b1};
            EXE_LHU_OP, EXE_SH_OP: d = '{is_mem: 1'b1, last: 2'd1, is_signed: 1'b0};
            EXE_LW_OP, EXE_SW_OP:  d = '{is_mem: 1'b1, last: 2'd3, is_signed: 1'b0};
            default:               d = '0;
        endcase
        return d;
    endfunction

    function automatic logic mem_misaligned(input logic [1:0] last, input logic [1:0] addr_lo);
        return ((last == 2'd1) && addr_lo[0]) || ((last == 2'd3) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_serial_if.sv
// Byte-wide req/ack memory port between the memory stage (master) and the memory (slave).
interface mem_serial_if
    import mem_serial_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_a_o;
    logic [MEM_BYTE_W-1:0] mem_do_o;
    logic [MEM_BYTE_W-1:0] mem_di_i;
    logic                  mem_ack_i;

    modport master (
        output mem_req_o, mem_we_o, mem_a_o, mem_do_o,
        input  mem_di_i, mem_ack_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_a_o, mem_do_o,
        output mem_di_i, mem_ack_i
    );
endinterface

// File: rtl/mem_serial_load_ext.sv
// Combinational load formatter: picks the low 1/2/4 bytes of the buffer and sign/zero extends.
module mem_load_ext
    import mem_serial_pkg::*;
(
    input  logic [DATA_W-1:0] data_buf_i,
    input  logic [1:0]        last_i,
    input  logic              sign_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = data_buf_i;
        case (last_i)
            2'd0:    data_o = {{24{sign_i & data_buf_i[7]}},  data_buf_i[7:0]};
            2'd1:    data_o = {{16{sign_i & data_buf_i[15]}}, data_buf_i[15:0]};
            default: data_o = data_buf_i;
        endcase
    end

endmodule

// File: rtl/mem_serial.sv
// RV32I memory-access stage: byte-serial loads/stores over a req/ack port, stalling the pipeline meanwhile.
// Optional feature macro MEM_ALIGN_CHECK_EN: misaligned half/word ops skip the bus and pulse misalign_o.
module mem_serial
    import mem_serial_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  alu_op_t           aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              is_load_i,
    input  reg_addr_t         wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    output reg_addr_t         wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_req_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    mem_serial_if.master      mem
);

    if (BYTE_W != MEM_BYTE_W) begin : g_bad_byte_w
        $error("mem_serial: BYTE_W must be 8");
    end

    logic [1:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        last_q, last_d;
    logic              sign_q, sign_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [7:0]        do_q, do_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
`endif

    mem_op_t           op_c;
    logic [DATA_W-1:0] load_data_c;

    assign op_c = mem_decode(aluop_i);

    mem_load_ext u_load_ext (
        .data_buf_i (data_q),
        .last_i     (last_q),
        .sign_i     (sign_q),
        .data_o     (load_data_c)
    );

    // Next-state and pipeline-facing outputs; non-memory ops fall through the defaults
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        sign_d      = sign_q;
        load_d      = load_q;
        data_d      = data_q;
        req_d       = req_q;
        we_d        = we_q;
        a_d         = a_q;
        do_d        = do_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (op_c.is_mem) begin
                    stall_req_o = 1'b1;
                    wreg_o      = 1'b0;
                    idx_d       = 2'd0;
                    last_d      = op_c.last;
                    sign_d      = op_c.is_signed;
                    load_d      = is_load_i;
                    data_d      = is_load_i ? '0 : reg2_i;
                    a_d         = mem_addr_i;
                    do_d        = reg2_i[7:0];
                    state_d     = MEM_XFER;
                    req_d       = 1'b1;
                    we_d        = !is_load_i;
`ifdef MEM_ALIGN_CHECK_EN
                    if (mem_misaligned(op_c.last, mem_addr_i[1:0])) begin
                        state_d    = MEM_DONE;
                        req_d      = 1'b0;
                        we_d       = 1'b0;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            MEM_XFER: begin
                stall_req_o = 1'b1;
                wreg_o      = 1'b0;
                if (mem.mem_ack_i) begin
                    if (load_q) begin
                        data_d[{idx_q, 3'b000} +: 8] = mem.mem_di_i;
                    end
                    if (idx_q == last_q) begin
                        state_d = MEM_DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        a_d   = a_q + ADDR_W'(1);
                        do_d  = data_q[{idx_d, 3'b000} +: 8];
                    end
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
                wdata_o = load_q ? load_data_c : '0;
`ifdef MEM_ALIGN_CHECK_EN
                if (misalign_q) begin
                    wreg_o = 1'b0;
                end
`endif
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // State and bus registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MEM_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            sign_q     <= 1'b0;
            load_q     <= 1'b0;
            data_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            a_q        <= '0;
            do_q       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            sign_q     <= sign_d;
            load_q     <= load_d;
            data_q     <= data_d;
            req_q      <= req_d;
            we_q       <= we_d;
            a_q        <= a_d;
            do_q       <= do_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign mem.mem_req_o = req_q;
    assign mem.mem_we_o  = we_q;
    assign mem.mem_a_o   = a_q;
    assign mem.mem_do_o  = do_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_mem_serial.sv
// Self-checking bench for mem_serial: byte-addressed memory slave with programmable ack delay plus a reference model.
module tb_mem_serial;
    import mem_serial_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    alu_op_t           aluop_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       reg2_i;
    logic              is_load_i;
    reg_addr_t         wd_i;
    logic              wreg_i;
    logic [31:0]       wdata_i;
    reg_addr_t         wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
    logic              stall_req_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic              misalign_o;
`endif

    mem_serial_if #(.ADDR_W(32)) bus ();

    mem_serial #(.ADDR_W(32), .BYTE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .is_load_i   (is_load_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_o  (misalign_o),
`endif
        .mem         (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [7:0]  mem_arr [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic [31:0] xfer_addr [$];
    logic        xfer_we   [$];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Memory slave: ack after ack_wait idle cycles of request, read data valid alongside ack
    always @(negedge clk) begin
        bus.mem_ack_i = (bus.mem_req_o === 1'b1) && (wait_cnt >= ack_wait);
        bus.mem_di_i  = (bus.mem_req_o === 1'b1) ? mem_rd(bus.mem_a_o) : 8'h00;
    end

    always @(posedge clk) begin
        if (rst === 1'b1 && bus.mem_req_o === 1'b1) begin
            if (bus.mem_ack_i === 1'b1) begin
                if (bus.mem_we_o === 1'b1) mem_arr[bus.mem_a_o] = bus.mem_do_o;
                xfer_addr.push_back(bus.mem_a_o);
                xfer_we.push_back(bus.mem_we_o);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input alu_op_t op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
            EXE_LW_OP, EXE_SW_OP:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic bit op_load(input alu_op_t op);
        return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
    endfunction

    function automatic bit op_signed(input alu_op_t op);
        return op inside {EXE_LB_OP, EXE_LH_OP};
    endfunction

    // Little-endian n-byte read from the reference memory, extended to 32 bits
    function automatic logic [31:0] model_load(input int n, input bit sgn, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_rd(addr + 32'(k))) << (8 * k));
        if (n < 4 && sgn && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    // Presents one op right after a rising edge and follows it to completion
    task automatic do_op(input alu_op_t op, input logic [31:0] addr, input logic [31:0] st,
                         input reg_addr_t wd, input logic wr, input int w, output logic [31:0] obs);
        int          n;
        bit          ld;
        bit          mis;
        int          cyc;
        int          stalls;
        bit          bad;
        int          lat;
        logic [31:0] exp;
        n  = op_size(op);
        ld = op_load(op);
        ack_wait = w;
        xfer_addr.delete();
        xfer_we.delete();
        aluop_i = op; mem_addr_i = addr; reg2_i = st; is_load_i = ld;
        wd_i = wd; wreg_i = wr; wdata_i = $urandom;
        #1;
        if (n == 0) begin
            obs = wdata_o;
            check("pass_wdata", wdata_o, wdata_i);
            check("pass_wreg", 32'(wreg_o), 32'(wr));
            check("pass_wd", 32'(wd_o), 32'(wd));
            check("pass_stall", 32'(stall_req_o), 32'd0);
            check("pass_req", 32'(bus.mem_req_o), 32'd0);
            @(posedge clk); #1;
            return;
        end
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
        cyc = 1; stalls = 0; bad = 1'b0;
        while (stall_req_o === 1'b1 && cyc < 300) begin
            stalls++;
            if (wreg_o !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        lat = mis ? 2 : 2 + n * (w + 1);
        exp = (ld && !mis) ? model_load(n, op_signed(op), addr) : 32'h0;
        obs = wdata_o;
        check("latency", 32'(cyc), 32'(lat));
        check("stall_cycles", 32'(stalls), 32'(lat - 1));
        check("wreg_low_in_stall", 32'(bad), 32'd0);
        check("done_wreg", 32'(wreg_o), mis ? 32'd0 : 32'(wr));
        check("done_wd", 32'(wd_o), 32'(wd));
        check("done_wdata", wdata_o, exp);
        check("done_req", 32'(bus.mem_req_o), 32'd0);
        check("xfer_count", 32'(xfer_addr.size()), mis ? 32'd0 : 32'(n));
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign_pulse", 32'(misalign_o), 32'(mis));
`endif
        for (int k = 0; k < xfer_addr.size() && k < n; k++) begin
            check("xfer_addr", xfer_addr[k], addr + 32'(k));
            check("xfer_we", 32'(xfer_we[k]), 32'(!ld));
        end
        if (!ld && !mis) begin
            for (int k = 0; k < n; k++) begin
                ref_mem[addr + 32'(k)] = st[8*k +: 8];
                check("store_byte", 32'(mem_rd(addr + 32'(k))), 32'(ref_rd(addr + 32'(k))));
            end
        end
        @(posedge clk); #1;
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign_clear", 32'(misalign_o), 32'd0);
`endif
    endtask

    task automatic set_byte(input logic [31:0] a, input logic [7:0] d);
        mem_arr[a] = d;
        ref_mem[a] = d;
    endtask

    initial begin
        logic [31:0] obs;
        logic [7:0]  b;
        int          guard;
        alu_op_t     ops [9];
        ops = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_ADD_OP};

        bus.mem_ack_i = 1'b0;
        bus.mem_di_i  = 8'h00;
        for (int a = 0; a < 1024; a++) begin
            b = 8'($urandom);
            set_byte(32'(a), b);
        end
        for (int a = 0; a < 256; a++) begin
            b = 8'($urandom);
            set_byte(32'hFFFF_FF00 + 32'(a), b);
        end

        rst = 1'b0;
        aluop_i = EXE_NOP_OP; mem_addr_i = '0; reg2_i = '0; is_load_i = 1'b0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_we", 32'(bus.mem_we_o), 32'd0);
        check("rst_addr", bus.mem_a_o, 32'd0);
        check("rst_do", 32'(bus.mem_do_o), 32'd0);
        check("rst_stall", 32'(stall_req_o), 32'd0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("rst_misalign", 32'(misalign_o), 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // LW, zero-wait memory
        set_byte(32'h100, 8'h78); set_byte(32'h101, 8'h56);
        set_byte(32'h102, 8'h34); set_byte(32'h103, 8'h12);
        do_op(EXE_LW_OP, 32'h100, 32'h0, 5'd3, 1'b1, 0, obs);
        check("lw_value", obs, 32'h1234_5678);

        // Byte/half sign and zero extension
        set_byte(32'h203, 8'h80);
        do_op(EXE_LB_OP, 32'h203, 32'h0, 5'd4, 1'b1, 0, obs);
        check("lb_value", obs, 32'hFFFF_FF80);
        do_op(EXE_LBU_OP, 32'h203, 32'h0, 5'd5, 1'b1, 1, obs);
        check("lbu_value", obs, 32'h0000_0080);
        set_byte(32'h10, 8'h01); set_byte(32'h11, 8'h80);
        do_op(EXE_LH_OP, 32'h10, 32'h0, 5'd6, 1'b1, 0, obs);
        check("lh_value", obs, 32'hFFFF_8001);

        // SH with slow acks
        do_op(EXE_SH_OP, 32'h40, 32'hCAFE_BEEF, 5'd0, 1'b0, 3, obs);
        check("sh_byte0", 32'(mem_rd(32'h40)), 32'hEF);
        check("sh_byte1", 32'(mem_rd(32'h41)), 32'hBE);

        // ALU passthrough
        aluop_i = EXE_ADD_OP; wdata_i = 32'h55; wreg_i = 1'b1; wd_i = 5'd9;
        #1;
        check("add_wdata", wdata_o, 32'h55);
        check("add_wreg", 32'(wreg_o), 32'd1);
        check("add_stall", 32'(stall_req_o), 32'd0);
        check("add_req", 32'(bus.mem_req_o), 32'd0);
        @(posedge clk); #1;

        // Reset during SW after two acks, then reissue
        b = mem_rd(32'h82);
        ack_wait = 0;
        xfer_addr.delete(); xfer_we.delete();
        aluop_i = EXE_SW_OP; mem_addr_i = 32'h80; reg2_i = 32'hA1B2_C3D4; is_load_i = 1'b0;
        wd_i = 5'd0; wreg_i = 1'b0;
        guard = 0;
        while (xfer_addr.size() < 2 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_mid_acks", 32'(xfer_addr.size()), 32'd2);
        rst = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_mid_byte0", 32'(mem_rd(32'h80)), 32'hD4);
        check("rst_mid_byte1", 32'(mem_rd(32'h81)), 32'hC3);
        check("rst_mid_byte2", 32'(mem_rd(32'h82)), 32'(b));
        @(posedge clk); #1;
        check("rst_mid_req_held", 32'(bus.mem_req_o), 32'd0);
        rst = 1'b1;
        do_op(EXE_SW_OP, 32'h80, 32'hA1B2_C3D4, 5'd0, 1'b0, 0, obs);

        // Misaligned word and address wrap-around
        do_op(EXE_LW_OP, 32'h102, 32'h0, 5'd7, 1'b1, 0, obs);
        do_op(EXE_LW_OP, 32'hFFFF_FFFE, 32'h0, 5'd8, 1'b1, 0, obs);
        do_op(EXE_SW_OP, 32'hFFFF_FFFC, 32'h1357_9BDF, 5'd0, 1'b0, 1, obs);
        do_op(EXE_LW_OP, 32'hFFFF_FFFC, 32'h0, 5'd8, 1'b1, 0, obs);

        // Random back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            alu_op_t     op;
            logic [31:0] addr;
            op   = ops[$urandom_range(0, 8)];
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'($urandom_range(0, 32'h3F0));
            do_op(op, addr, $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 2)), obs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
